fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding + hazard unit for the RV32I pipeline.
//  - Forwards from EX/MEM (priority) and MEM/WB into NUM_SRC EX-stage operands.
//  - Detects load-use hazards with a stall FSM of LD_STALL bubbles.
//  - Tracks one in-flight multi-cycle result (MC_LAT cycles) and stalls its consumers.

---
 rtl/fwd_hazard_unit.sv | 138 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects, load-use stall FSM and single-entry multi-cycle scoreboard for the RV32I pipeline.
// Optional FWD_STATS_EN macro adds free-running stall-cycle counters ld_stall_cnt / mc_stall_cnt.
module fwd_hazard_unit #(
   parameter int NUM_SRC  = 2,
   parameter int RA_W     = 5,
   parameter int LD_STALL = 1,
   parameter int MC_LAT   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_SRC*RA_W-1:0] ex_rs,
   input  logic [NUM_SRC*RA_W-1:0] id_rs,
   input  logic                    id_valid,
   input  logic [RA_W-1:0]         id_ex_rd,
   input  logic                    id_ex_memRead,
   input  logic [RA_W-1:0]         ex_mem_rd,
   input  logic                    ex_mem_regWrite,
   input  logic [RA_W-1:0]         mem_wb_rd,
   input  logic                    mem_wb_regWrite,
   input  logic                    mc_issue,
   input  logic [RA_W-1:0]         mc_rd,
   output logic [2*NUM_SRC-1:0]    fwd_sel,
   output logic                    stall,
   output logic                    flush_ex,
   output logic                    mc_busy,
   output logic                    mc_err
`ifdef FWD_STATS_EN
   ,
   output logic [31:0]             ld_stall_cnt,
   output logic [31:0]             mc_stall_cnt
`endif
);

   localparam int LDW = $clog2(LD_STALL + 1);
   localparam int MCW = $clog2(MC_LAT + 1);

   typedef enum logic {IDLE, LDS} ld_state_e;

   ld_state_e           state_q;
   logic [LDW-1:0]      ld_cnt_q;
   logic [MCW-1:0]      mc_cnt_q, mc_cnt_d;
   logic [RA_W-1:0]     mc_rd_q, mc_rd_d;
   logic                mc_err_q, mc_err_d;

   logic [2*NUM_SRC-1:0] fwd_w;
   logic                 ld_match, mc_match;
   logic                 ld_hit, mc_hit, mc_busy_w, ld_stall_w, stall_w;

   always_comb begin
      fwd_w    = '0;
      ld_match = 1'b0;
      mc_match = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (ex_mem_regWrite && (ex_mem_rd != '0) && (ex_mem_rd == ex_rs[i*RA_W +: RA_W]))
            fwd_w[2*i +: 2] = 2'b10;
         else if (mem_wb_regWrite && (mem_wb_rd != '0) && (mem_wb_rd == ex_rs[i*RA_W +: RA_W]))
            fwd_w[2*i +: 2] = 2'b01;
         if (id_rs[i*RA_W +: RA_W] == id_ex_rd) ld_match = 1'b1;
         if (id_rs[i*RA_W +: RA_W] == mc_rd_q)  mc_match = 1'b1;
      end
   end

   assign mc_busy_w  = (mc_cnt_q != '0);
   assign ld_hit     = id_valid & id_ex_memRead & (id_ex_rd != '0) & ld_match;
   assign mc_hit     = id_valid & mc_busy_w & (mc_rd_q != '0) & mc_match;
   // A load already in LDS has been replaced by a bubble, so ld_hit is not consulted there.
   assign ld_stall_w = ((state_q == IDLE) & ld_hit) | (state_q == LDS);
   assign stall_w    = ld_stall_w | mc_hit;

   assign fwd_sel  = rst ? '0 : fwd_w;
   assign stall    = ~rst & stall_w;
   assign flush_ex = ~rst & stall_w;
   assign mc_busy  = ~rst & mc_busy_w;
   assign mc_err   = ~rst & mc_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ld_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (ld_hit && (LD_STALL > 1)) begin
               state_q  <= LDS;
               ld_cnt_q <= LDW'(LD_STALL - 1);
            end
            LDS: begin
               ld_cnt_q <= ld_cnt_q - LDW'(1);
               if (ld_cnt_q == LDW'(1)) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A second issue while busy is dropped; the pending countdown carries on untouched.
   always_comb begin
      mc_cnt_d = mc_cnt_q;
      mc_rd_d  = mc_rd_q;
      mc_err_d = mc_err_q;
      if (mc_issue && !mc_busy_w) begin
         mc_cnt_d = MCW'(MC_LAT);
         mc_rd_d  = mc_rd;
      end else begin
         if (mc_issue)  mc_err_d = 1'b1;
         if (mc_busy_w) mc_cnt_d = mc_cnt_q - MCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mc_cnt_q <= '0;
         mc_rd_q  <= '0;
         mc_err_q <= 1'b0;
      end else begin
         mc_cnt_q <= mc_cnt_d;
         mc_rd_q  <= mc_rd_d;
         mc_err_q <= mc_err_d;
      end
   end

`ifdef FWD_STATS_EN
   logic [31:0] ld_stall_cnt_q, mc_stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ld_stall_cnt_q <= '0;
         mc_stall_cnt_q <= '0;
      end else begin
         if (ld_stall_w) ld_stall_cnt_q <= ld_stall_cnt_q + 32'd1;
         if (mc_hit)     mc_stall_cnt_q <= mc_stall_cnt_q + 32'd1;
      end
   end

   assign ld_stall_cnt = rst ? '0 : ld_stall_cnt_q;
   assign mc_stall_cnt = rst ? '0 : mc_stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed plus randomized bench for fwd_hazard_unit against a cycle-count reference model.
module tb_fwd_hazard_unit;

   localparam int NS  = 2;
   localparam int RW  = 5;
   localparam int LDS = 3;
   localparam int MCL = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [NS*RW-1:0] ex_rs, id_rs;
   logic           id_valid, id_ex_memRead, ex_mem_regWrite, mem_wb_regWrite, mc_issue;
   logic [RW-1:0]  id_ex_rd, ex_mem_rd, mem_wb_rd, mc_rd;
   logic [2*NS-1:0] fwd_sel;
   logic           stall, flush_ex, mc_busy, mc_err;
`ifdef FWD_STATS_EN
   logic [31:0]    ld_stall_cnt, mc_stall_cnt;
`endif

   always #5 clk = ~clk;

   fwd_hazard_unit #(.NUM_SRC(NS), .RA_W(RW), .LD_STALL(LDS), .MC_LAT(MCL)) dut (
      .clk(clk), .rst(rst), .ex_rs(ex_rs), .id_rs(id_rs), .id_valid(id_valid),
      .id_ex_rd(id_ex_rd), .id_ex_memRead(id_ex_memRead),
      .ex_mem_rd(ex_mem_rd), .ex_mem_regWrite(ex_mem_regWrite),
      .mem_wb_rd(mem_wb_rd), .mem_wb_regWrite(mem_wb_regWrite),
      .mc_issue(mc_issue), .mc_rd(mc_rd),
      .fwd_sel(fwd_sel), .stall(stall), .flush_ex(flush_ex),
      .mc_busy(mc_busy), .mc_err(mc_err)
`ifdef FWD_STATS_EN
      , .ld_stall_cnt(ld_stall_cnt), .mc_stall_cnt(mc_stall_cnt)
`endif
   );

   int errors = 0;
   int checks = 0;

   // Reference model: stall cycles still owed by a load, cycles until the mc result lands.
   int ld_left = 0, mc_left = 0, mc_rd_m = 0, err_m = 0;
   int ldc_m = 0, mcc_m = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rs_of(input logic [NS*RW-1:0] v, input int i);
      return int'(v[i*RW +: RW]);
   endfunction

   // Compare all outputs with the model (call at negedge), then advance across the next edge.
   task automatic step();
      logic [31:0] esel;
      bit ldh, mch, sld, any_ld, any_mc;
      esel = 0; any_ld = 0; any_mc = 0;
      for (int i = 0; i < NS; i++) begin
         int s;
         s = rs_of(ex_rs, i);
         if (ex_mem_regWrite && ex_mem_rd != 0 && int'(ex_mem_rd) == s) esel |= 32'(2) << (2*i);
         else if (mem_wb_regWrite && mem_wb_rd != 0 && int'(mem_wb_rd) == s) esel |= 32'(1) << (2*i);
         if (rs_of(id_rs, i) == int'(id_ex_rd)) any_ld = 1;
         if (rs_of(id_rs, i) == mc_rd_m) any_mc = 1;
      end
      ldh = id_valid && id_ex_memRead && id_ex_rd != 0 && any_ld;
      mch = id_valid && mc_left > 0 && mc_rd_m != 0 && any_mc;
      sld = (ld_left > 0) || ldh;
      if (rst) begin
         chk("m_fwd_sel", 32'(fwd_sel), 0);
         chk("m_stall", 32'(stall), 0);
         chk("m_flush", 32'(flush_ex), 0);
         chk("m_busy", 32'(mc_busy), 0);
         chk("m_err", 32'(mc_err), 0);
      end else begin
         chk("m_fwd_sel", 32'(fwd_sel), esel);
         chk("m_stall", 32'(stall), 32'(sld || mch));
         chk("m_flush", 32'(flush_ex), 32'(sld || mch));
         chk("m_busy", 32'(mc_busy), 32'(mc_left > 0));
         chk("m_err", 32'(mc_err), 32'(err_m));
      end
`ifdef FWD_STATS_EN
      chk("m_ld_cnt", ld_stall_cnt, rst ? 0 : 32'(ldc_m));
      chk("m_mc_cnt", mc_stall_cnt, rst ? 0 : 32'(mcc_m));
`endif
      @(posedge clk);
      if (rst) begin
         ld_left = 0; mc_left = 0; mc_rd_m = 0; err_m = 0; ldc_m = 0; mcc_m = 0;
      end else begin
         if (sld) ldc_m++;
         if (mch) mcc_m++;
         if (ld_left > 0) ld_left--;
         else if (ldh) ld_left = LDS - 1;
         if (mc_issue && mc_left == 0) begin
            mc_left = MCL;
            mc_rd_m = int'(mc_rd);
         end else begin
            if (mc_issue) err_m = 1;
            if (mc_left > 0) mc_left--;
         end
      end
      #1;
   endtask

   initial begin
      rst = 1; ex_rs = '0; id_rs = '0; id_valid = 0; id_ex_rd = '0; id_ex_memRead = 0;
      ex_mem_rd = '0; ex_mem_regWrite = 0; mem_wb_rd = '0; mem_wb_regWrite = 0;
      mc_issue = 0; mc_rd = '0;

      // Reset: everything low, even with a forwarding match present.
      ex_rs = {5'd0, 5'd5}; ex_mem_rd = 5'd5; ex_mem_regWrite = 1;
      @(negedge clk);
      chk("rst_fwd", 32'(fwd_sel), 0);
      chk("rst_stall", 32'(stall), 0);
      step();
      @(negedge clk); step();
      rst = 0;

      // Forwarding priority and x0.
      mem_wb_rd = 5'd5; mem_wb_regWrite = 1;
      @(negedge clk);
      chk("fwd_exmem_wins", 32'(fwd_sel[1:0]), 32'(2));
      step();
      ex_mem_regWrite = 0;
      @(negedge clk);
      chk("fwd_memwb", 32'(fwd_sel[1:0]), 32'(1));
      step();
      ex_rs = {5'd0, 5'd0}; ex_mem_rd = 5'd0; ex_mem_regWrite = 1; mem_wb_rd = 5'd0;
      @(negedge clk);
      chk("fwd_x0", 32'(fwd_sel[3:2]), 0);
      step();
      ex_mem_regWrite = 0; mem_wb_regWrite = 0;

      // Load-use: exactly LD_STALL stall cycles, bubble in EX after the first.
      id_valid = 1; id_ex_memRead = 1; id_ex_rd = 5'd7; id_rs = {5'd0, 5'd7};
      @(negedge clk); chk("ld_stall_c0", 32'(stall), 1); step();
      id_ex_memRead = 0;
      @(negedge clk); chk("ld_stall_c1", 32'(flush_ex), 1); step();
      @(negedge clk); chk("ld_stall_c2", 32'(stall), 1); step();
      @(negedge clk); chk("ld_stall_end", 32'(stall), 0); step();

      // Multi-cycle scoreboard, dropped second issue, consumer of a different reg.
      id_rs = {5'd0, 5'd0}; mc_issue = 1; mc_rd = 5'd9;
      @(negedge clk); chk("mc_busy_c0", 32'(mc_busy), 0); step();
      mc_issue = 0; id_rs = {5'd0, 5'd9};
      @(negedge clk); chk("mc_stall_c1", 32'(stall), 1); chk("mc_busy_c1", 32'(mc_busy), 1); step();
      mc_issue = 1; mc_rd = 5'd3;
      @(negedge clk); chk("mc_err_c2", 32'(mc_err), 0); step();
      mc_issue = 0;
      @(negedge clk); chk("mc_err_c3", 32'(mc_err), 1); chk("mc_stall_c3", 32'(stall), 1); step();
      id_rs = {5'd0, 5'd3};
      @(negedge clk); chk("mc_rd_kept", 32'(stall), 0); chk("mc_busy_c4", 32'(mc_busy), 1); step();
      id_rs = {5'd0, 5'd9};
      @(negedge clk); chk("mc_busy_c5", 32'(mc_busy), 0); chk("mc_stall_c5", 32'(stall), 0);
`ifdef FWD_STATS_EN
      chk("stat_ld", ld_stall_cnt, 32'd3);
      chk("stat_mc", mc_stall_cnt, 32'd3);
`endif
      step();

      // Reset during the second load stall cycle, with a simultaneous mc_issue.
      id_ex_memRead = 1; id_ex_rd = 5'd7; id_rs = {5'd0, 5'd7};
      @(negedge clk); chk("rl_stall_c0", 32'(stall), 1); step();
      id_ex_memRead = 0; rst = 1; mc_issue = 1; mc_rd = 5'd9;
      @(negedge clk); chk("rl_stall_rst", 32'(stall), 0); step();
      rst = 0; mc_issue = 0; id_rs = {5'd9, 5'd7};
      @(negedge clk);
      chk("rl_stall_after", 32'(stall), 0);
      chk("rl_busy_after", 32'(mc_busy), 0);
      chk("rl_err_after", 32'(mc_err), 0);
      step();

      // Randomized traffic over a small register range to provoke frequent matches.
      for (int n = 0; n < 600; n++) begin
         rst             = ($urandom_range(0, 59) == 0);
         ex_rs           = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         id_rs           = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         id_valid        = ($urandom_range(0, 7) != 0);
         id_ex_rd        = 5'($urandom_range(0, 3));
         id_ex_memRead   = ($urandom_range(0, 3) == 0);
         ex_mem_rd       = 5'($urandom_range(0, 3));
         ex_mem_regWrite = $urandom_range(0, 1) == 1;
         mem_wb_rd       = 5'($urandom_range(0, 3));
         mem_wb_regWrite = $urandom_range(0, 1) == 1;
         mc_issue        = ($urandom_range(0, 5) == 0);
         mc_rd           = 5'($urandom_range(0, 3));
         @(negedge clk);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
